// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet-control FSM.
package router_pkg;

  localparam int ADDR_W   = 2;
  localparam int NUM_DEST = 3;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  // Packet-control states, 3-bit binary; all eight codes are used.
  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  // Bundle of the Moore outputs so they can be decoded and registered together.
  typedef struct packed {
    logic detect_add;
    logic write_enb_reg;
    logic lfd_state;
    logic ld_state;
    logic laf_state;
    logic full_state;
    logic rst_int_reg;
    logic busy;
  } fsm_outs_t;

  // Moore output decode for a given state.
  function automatic fsm_outs_t decode_outputs(input state_t st);
    fsm_outs_t o;
    o = '0;
    case (st)
      DECODE_ADDRESS: begin
        o.detect_add = 1'b1;
      end
      LOAD_FIRST_DATA: begin
        o.lfd_state = 1'b1;
        o.busy      = 1'b1;
      end
      LOAD_DATA: begin
        o.ld_state      = 1'b1;
        o.write_enb_reg = 1'b1;
      end
      LOAD_PARITY: begin
        o.write_enb_reg = 1'b1;
        o.busy          = 1'b1;
      end
      FIFO_FULL_STATE: begin
        o.full_state = 1'b1;
        o.busy       = 1'b1;
      end
      LOAD_AFTER_FULL: begin
        o.laf_state     = 1'b1;
        o.write_enb_reg = 1'b1;
        o.busy          = 1'b1;
      end
      WAIT_TILL_EMPTY: begin
        o.busy = 1'b1;
      end
      CHECK_PARITY_ERROR: begin
        o.rst_int_reg = 1'b1;
        o.busy        = 1'b1;
      end
      default: begin
        o = '0;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Packet-control FSM of the 1x3 router: header decode, wait-for-empty,
// header/payload/parity load sequencing and FIFO-full stall handling.
module router_fsm
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              fifo_empty0,
  input  logic              fifo_empty1,
  input  logic              fifo_empty2,
  input  logic              soft_reset0,
  input  logic              soft_reset1,
  input  logic              soft_reset2,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              detect_add,
  output logic              write_enb_reg,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              busy
);

  state_t            state_r;
  state_t            state_next_s;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_next_s;
  logic [ADDR_W-1:0] sel_idx_s;
  logic              sel_empty_s;
  logic              sel_sr_s;
  logic              header_ok_s;
  fsm_outs_t         outs_r;

  // A header is acceptable only when valid and not addressed to the invalid code.
  always_comb begin
    header_ok_s = pkt_valid && (data_in != ADDR_INVALID);
  end

  // Empty flag follows the incoming header while decoding, the latched address otherwise.
  always_comb begin
    sel_idx_s   = addr_q;
    sel_empty_s = 1'b0;
    if (state_r == DECODE_ADDRESS) begin
      sel_idx_s = data_in;
    end else begin
      sel_idx_s = addr_q;
    end
    case (sel_idx_s)
      2'd0:    sel_empty_s = fifo_empty0;
      2'd1:    sel_empty_s = fifo_empty1;
      2'd2:    sel_empty_s = fifo_empty2;
      default: sel_empty_s = 1'b0;
    endcase
  end

  // Read-timeout reset of the destination currently being served.
  always_comb begin
    sel_sr_s = 1'b0;
    case (addr_q)
      2'd0:    sel_sr_s = soft_reset0;
      2'd1:    sel_sr_s = soft_reset1;
      2'd2:    sel_sr_s = soft_reset2;
      default: sel_sr_s = 1'b0;
    endcase
  end

  // Destination latch: capture a good header address, otherwise hold.
  always_comb begin
    addr_next_s = addr_q;
    if ((state_r == DECODE_ADDRESS) && header_ok_s) begin
      addr_next_s = data_in;
    end else begin
      addr_next_s = addr_q;
    end
  end

  // Next-state logic; a soft reset outside DECODE_ADDRESS overrides everything.
  always_comb begin
    state_next_s = state_r;
    if ((state_r != DECODE_ADDRESS) && sel_sr_s) begin
      state_next_s = DECODE_ADDRESS;
    end else begin
      case (state_r)
        DECODE_ADDRESS: begin
          if (header_ok_s && sel_empty_s) begin
            state_next_s = LOAD_FIRST_DATA;
          end else if (header_ok_s) begin
            state_next_s = WAIT_TILL_EMPTY;
          end else begin
            state_next_s = DECODE_ADDRESS;
          end
        end
        WAIT_TILL_EMPTY: begin
          if (sel_empty_s) begin
            state_next_s = LOAD_FIRST_DATA;
          end else begin
            state_next_s = WAIT_TILL_EMPTY;
          end
        end
        LOAD_FIRST_DATA: begin
          state_next_s = LOAD_DATA;
        end
        LOAD_DATA: begin
          // Full wins over pkt_valid falling in the same cycle.
          if (fifo_full) begin
            state_next_s = FIFO_FULL_STATE;
          end else if (!pkt_valid) begin
            state_next_s = LOAD_PARITY;
          end else begin
            state_next_s = LOAD_DATA;
          end
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) begin
            state_next_s = LOAD_AFTER_FULL;
          end else begin
            state_next_s = FIFO_FULL_STATE;
          end
        end
        LOAD_AFTER_FULL: begin
          if (parity_done) begin
            state_next_s = DECODE_ADDRESS;
          end else if (low_pkt_valid) begin
            state_next_s = LOAD_PARITY;
          end else begin
            state_next_s = LOAD_DATA;
          end
        end
        LOAD_PARITY: begin
          state_next_s = CHECK_PARITY_ERROR;
        end
        CHECK_PARITY_ERROR: begin
          if (fifo_full) begin
            state_next_s = FIFO_FULL_STATE;
          end else begin
            state_next_s = DECODE_ADDRESS;
          end
        end
        default: begin
          state_next_s = DECODE_ADDRESS;
        end
      endcase
    end
  end

  // State, address and output registers; outputs are pre-decoded from the
  // next state so they always reflect the current state with no comb path.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= DECODE_ADDRESS;
      addr_q  <= '0;
      outs_r  <= decode_outputs(DECODE_ADDRESS);
    end else begin
      state_r <= state_next_s;
      addr_q  <= addr_next_s;
      outs_r  <= decode_outputs(state_next_s);
    end
  end

  assign detect_add    = outs_r.detect_add;
  assign write_enb_reg = outs_r.write_enb_reg;
  assign lfd_state     = outs_r.lfd_state;
  assign ld_state      = outs_r.ld_state;
  assign laf_state     = outs_r.laf_state;
  assign full_state    = outs_r.full_state;
  assign rst_int_reg   = outs_r.rst_int_reg;
  assign busy          = outs_r.busy;

endmodule
